// File: rtl/pwm_audio_demod.sv
// PWM audio receiver: recovers per-period duty and period from a single-bit PWM
// stream on a GPIO pin, with loss-of-signal detection and stuck-level capture.
module pwm_audio_demod #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty,
  output logic [CNT_W-1:0] period,
  output logic             sample_valid,
  output logic             no_signal,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             sv_q, sv_d;
  logic             ns_q, ns_d;
  logic             stuck_q, stuck_d;
  logic             to_q, to_d;

  // A line stuck high reports full-scale duty, stuck low reports zero.
  function automatic logic [CNT_W-1:0] stuck_duty(input logic lvl);
    return lvl ? {CNT_W{1'b1}} : '0;
  endfunction

  // Synchronizer stage: pwm_in is asynchronous, s3 is the one-cycle-old copy for edge detect.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Measurement stage: counters, FSM and the registered sample outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      duty_q   <= '0;
      period_q <= '0;
      sv_q     <= 1'b0;
      ns_q     <= 1'b1;
      stuck_q  <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      sv_q     <= sv_d;
      ns_q     <= ns_d;
      stuck_q  <= stuck_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    hi_d     = hi_q;
    duty_d   = duty_q;
    period_d = period_q;
    sv_d     = 1'b0;
    ns_d     = ns_q;
    stuck_d  = stuck_q;
    to_d     = to_q;

    if (!en) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
      to_d    = 1'b0;
    end else if (rise) begin
      // Rise beats a coincident timeout, so a period of exactly TIMEOUT still measures.
      per_d = {{(CNT_W-1){1'b0}}, 1'b1};
      hi_d  = {{(CNT_W-1){1'b0}}, 1'b1};
      to_d  = 1'b0;
      if (state_q == IDLE) begin
        state_d = MEASURE;
        ns_d    = 1'b0;
      end else begin
        period_d = per_q;
        duty_d   = hi_q;
        sv_d     = 1'b1;
      end
    end else if (per_q == TO_CNT) begin
      // Counters park at TIMEOUT; to_q keeps the timeout sample from repeating.
      if (!to_q) begin
        to_d     = 1'b1;
        state_d  = IDLE;
        ns_d     = 1'b1;
        stuck_d  = s2_q;
        period_d = '0;
        duty_d   = stuck_duty(s2_q);
        sv_d     = 1'b1;
      end
    end else begin
      per_d = per_q + 1'b1;
      if (s2_q) begin
        hi_d = hi_q + 1'b1;
      end
    end
  end

  assign duty         = duty_q;
  assign period       = period_q;
  assign sample_valid = sv_q;
  assign no_signal    = ns_q;
  assign stuck_level  = stuck_q;

endmodule

// File: tb/tb_pwm_audio_demod.sv
// Bench for pwm_audio_demod: directed and random PWM streams checked every cycle
// against an edge-time/deadline reference model.
module tb_pwm_audio_demod;
  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 1000;
  localparam int MAXV    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] duty;
  logic [CNT_W-1:0] period;
  logic             sample_valid;
  logic             no_signal;
  logic             stuck_level;

  int checks = 0;
  int failures = 0;

  pwm_audio_demod #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .duty(duty), .period(period), .sample_valid(sample_valid),
    .no_signal(no_signal), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: S(m) is the level seen at clock m (0 while held in reset/disabled);
  // a raw edge seen at clock k is acted on at clock k+2.
  int m = 0;
  int h1 = 0, h2 = 0, h3 = 0;
  int edges = 0, last_dec = 0, deadline = 0, hi_acc = 0;
  bit to_fired = 0;
  int e_duty = 0, e_period = 0;
  bit e_sv = 0, e_ns = 1, e_stuck = 0;
  bit model_ok = 0;

  task automatic model_step();
    m++;
    e_sv = 0;
    if (rst || !en) begin
      if (rst) begin
        e_duty = 0; e_period = 0; e_ns = 1; e_stuck = 0;
      end
      h1 = 0; h2 = 0; h3 = 0;
      edges = 0; to_fired = 0; hi_acc = 0;
      deadline = m + TIMEOUT + 1;
    end else begin
      if (h2 == 1 && h3 == 0) begin
        if (edges > 0) begin
          e_sv = 1; e_period = m - last_dec; e_duty = hi_acc;
        end else begin
          e_ns = 0;
        end
        edges++;
        last_dec = m;
        deadline = m + TIMEOUT;
        hi_acc = 1;
        to_fired = 0;
      end else begin
        if (!to_fired && m == deadline) begin
          e_sv = 1; e_period = 0; e_duty = (h2 != 0) ? MAXV : 0;
          e_stuck = (h2 != 0); e_ns = 1;
          to_fired = 1; edges = 0;
        end
        hi_acc += h2;
      end
      h3 = h2; h2 = h1; h1 = int'(pwm_in);
    end
    model_ok = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      check("sample_valid", 32'(sample_valid), 32'(e_sv));
      check("duty", 32'(duty), 32'(e_duty));
      check("period", 32'(period), 32'(e_period));
      check("no_signal", 32'(no_signal), 32'(e_ns));
      check("stuck_level", 32'(stuck_level), 32'(e_stuck));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pwm_run(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = 1'b1;
      idle(h);
      pwm_in = 1'b0;
      idle(p - h);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p, h;
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
    idle(3);
    rst = 1'b0; en = 1'b1;

    // steady 64/256, then duty changes including a single-clock pulse
    pwm_run(256, 64, 6);
    pwm_run(256, 200, 3);
    pwm_run(256, 1, 3);

    // line stuck low, then stuck high, then recovery
    pwm_in = 1'b0;
    reset_pulse();
    idle(1100);
    reset_pulse();
    pwm_in = 1'b1;
    idle(1100);
    pwm_in = 1'b0;
    pwm_run(256, 64, 3);

    // reset 100 clocks into a period
    pwm_in = 1'b1; idle(64);
    pwm_in = 1'b0; idle(35);
    reset_pulse();
    idle(155);
    pwm_run(256, 64, 4);

    // enable dropped for 50 clocks mid-stream
    pwm_in = 1'b1; idle(64);
    pwm_in = 1'b0; idle(50);
    en = 1'b0; idle(50);
    en = 1'b1; idle(92);
    pwm_run(256, 64, 4);

    // periods at and around the timeout
    pwm_run(999, 300, 3);
    pwm_run(1000, 300, 3);
    pwm_run(1001, 300, 2);

    // random periods and duties, occasional enable glitch
    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(1100, 3));
      h = int'($urandom_range(p - 1, 1));
      pwm_run(p, h, int'($urandom_range(3, 1)));
      if ($urandom_range(4, 0) == 0) begin
        en = 1'b0;
        idle(int'($urandom_range(20, 1)));
        en = 1'b1;
      end
    end
    pwm_in = 1'b0;
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
